addr_count_queue: RTL and testbench

Registered buffering stage directly downstream of the address-calculation stage. Captures each 16-bit `count` result with a valid strobe into a small first-word-fall-through FIFO, then presents it to the memory request port under a valid/ready handshake. The calculation stage is purely combinational and cannot stall, so this block also records any dropped results in a sticky overflow flag. An optional range check tags each entry that exceeds a programmed limit.

---
 rtl/addr_count_queue.sv | 102 ++++++++++
 tb/tb_addr_count_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/addr_count_queue.sv
// addr_count_queue: first-word-fall-through buffer between the address calc stage and the memory request port.
// Entries become visible one cycle after their push edge; the optional out-of-range tag is built only with ADDR_COUNT_QUEUE_RANGE_CHECK_EN.
module addr_count_queue #(
  parameter int          DEPTH = 4,
  parameter int          CW    = 16,
  parameter int unsigned LIMIT = 32'h0000_00FF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [CW-1:0]              in_count,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [CW-1:0]              out_count,
  output logic                       out_oor,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..16");
  end
  if (64'(LIMIT) >= (64'd1 << CW)) begin : g_bad_limit
    $error("LIMIT does not fit in CW bits");
  end

  logic [CW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, drop;

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign out_count = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign ovf       = ovf_q;

  always_comb begin
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    drop     = in_valid && !in_ready;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    // A fresh drop outranks a clear in the same cycle.
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_count;
      end
    end
  end

`ifdef ADDR_COUNT_QUEUE_RANGE_CHECK_EN
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic oor_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        oor_q[i] <= 1'b0;
      end
    end else if (push) begin
      oor_q[wr_ptr_q] <= (in_count > LIMIT_C);
    end
  end

  assign out_oor = oor_q[rd_ptr_q];
`else
  assign out_oor = 1'b0;
`endif

endmodule

// File: tb/tb_addr_count_queue.sv
// Bench for addr_count_queue: directed vector table, reset/stream sequences, then random traffic against a queue model.
module tb_addr_count_queue;

  localparam int          DEPTH = 4;
  localparam int          CW    = 16;
  localparam logic [15:0] LIM   = 16'h00FF;
`ifdef ADDR_COUNT_QUEUE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [CW-1:0] in_count;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_count;
  logic          out_oor;
  logic          out_ready;
  logic [2:0]    level;
  logic          ovf;
  logic          ovf_clr;

  int errors = 0;
  int checks = 0;

  addr_count_queue #(.DEPTH(DEPTH), .CW(CW), .LIMIT(32'h00FF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_count (out_count),
    .out_oor   (out_oor),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          iv;
    logic [15:0] cnt;
    bit          ordy;
    bit          clr;
    int          lvl;
    bit          eovf;
    logic [15:0] head;
    bit          oor;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit iv, input logic [15:0] cnt, input bit ordy, input bit clr);
    in_valid  = iv;
    in_count  = cnt;
    out_ready = ordy;
    ovf_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit iv, input logic [15:0] cnt, input bit ordy, input bit clr,
                     input int lvl, input bit eovf, input logic [15:0] head, input bit oor);
    vec_t v;
    v.iv = iv; v.cnt = cnt; v.ordy = ordy; v.clr = clr;
    v.lvl = lvl; v.eovf = eovf; v.head = head; v.oor = oor;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    in_valid = 0; in_count = '0; out_ready = 0; ovf_clr = 0;
    rst = 1'b1;
    #12;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reference model: ordered list of {oor, count} plus a sticky flag.
  logic [16:0] mq[$];
  bit          movf;

  initial begin
    logic [15:0] v;
    bit iv, ordy, clr, ir, ov;

    do_reset();
    chk("rst_level", 32'(level), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_out_oor", 32'(out_oor), 0);

    // iv cnt ordy clr | lvl ovf head oor
    add(1, 16'h0080, 0, 0, 1, 0, 16'h0080, 0);
    add(1, 16'h0105, 0, 0, 2, 0, 16'h0080, 0);
    add(1, 16'h00FF, 0, 0, 3, 0, 16'h0080, 0);
    add(0, 16'h0000, 1, 0, 2, 0, 16'h0105, 1);
    add(0, 16'h0000, 1, 0, 1, 0, 16'h00FF, 0);
    add(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
    add(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);  // pop on empty
    add(1, 16'h0001, 0, 0, 1, 0, 16'h0001, 0);
    add(1, 16'h0002, 0, 0, 2, 0, 16'h0001, 0);
    add(1, 16'h0003, 0, 0, 3, 0, 16'h0001, 0);
    add(1, 16'h0004, 0, 0, 4, 0, 16'h0001, 0);
    add(1, 16'h0005, 0, 0, 4, 1, 16'h0001, 0);  // dropped
    add(0, 16'h0000, 0, 1, 4, 0, 16'h0001, 0);
    add(1, 16'h0006, 1, 0, 3, 1, 16'h0002, 0);  // full: pop, drop
    add(1, 16'h0007, 0, 1, 4, 0, 16'h0002, 0);
    add(1, 16'h0008, 0, 1, 4, 1, 16'h0002, 0);  // set beats clear
    add(0, 16'h0000, 1, 1, 3, 0, 16'h0003, 0);
    add(0, 16'h0000, 1, 0, 2, 0, 16'h0004, 0);
    add(1, 16'hAAAA, 1, 0, 2, 0, 16'h0007, 0);  // push+pop at level 2
    add(1, 16'hBBBB, 1, 0, 2, 0, 16'hAAAA, 1);
    add(0, 16'h0000, 1, 0, 1, 0, 16'hBBBB, 1);
    add(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
    add(1, 16'h00FF, 0, 0, 1, 0, 16'h00FF, 0);
    add(1, 16'h0100, 0, 0, 2, 0, 16'h00FF, 0);
    add(1, 16'hFF90, 0, 0, 3, 0, 16'h00FF, 0);
    add(0, 16'h0000, 1, 0, 2, 0, 16'h0100, 1);
    add(0, 16'h0000, 1, 0, 1, 0, 16'hFF90, 1);
    add(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
    add(1, 16'h1234, 1, 0, 1, 0, 16'h1234, 0);  // push+pop at level 0
    add(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].iv, tbl[i].cnt, tbl[i].ordy, tbl[i].clr);
      chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(tbl[i].eovf));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].lvl != 0));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].lvl != DEPTH));
      if (tbl[i].lvl != 0) begin
        chk($sformatf("v%0d_out_count", i), 32'(out_count), 32'(tbl[i].head));
        chk($sformatf("v%0d_out_oor", i), 32'(out_oor), 32'(RC && tbl[i].oor));
      end
    end

    // Streaming across pointer wraps: each value appears the cycle after its push.
    for (int i = 0; i < 10; i++) begin
      v = 16'h0F00 + 16'(i * 37);
      cyc(1, v, 1, 0);
      chk($sformatf("stream%0d_level", i), 32'(level), 1);
      chk($sformatf("stream%0d_count", i), 32'(out_count), 32'(v));
    end
    cyc(0, 16'h0000, 1, 0);
    chk("stream_drain", 32'(level), 0);

    // Asynchronous reset mid-stream with ovf set and level 3.
    for (int i = 0; i < 5; i++) cyc(1, 16'(16'h0200 + i), 0, 0);
    cyc(0, 16'h0000, 1, 0);
    chk("prereset_level", 32'(level), 3);
    chk("prereset_ovf", 32'(ovf), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_level", 32'(level), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 16'h0ABC, 0, 0);
    chk("postrst_level", 32'(level), 1);
    chk("postrst_count", 32'(out_count), 32'h0ABC);

    // Random traffic against the model.
    do_reset();
    mq.delete();
    movf = 0;
    for (int n = 0; n < 400; n++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 5);
      clr  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       v = 16'($urandom);
        1:       v = 16'h00F8 + 16'($urandom_range(0, 15));
        2:       v = 16'hFF80 + 16'($urandom_range(0, 127));
        default: v = 16'($urandom_range(0, 255));
      endcase
      ir = (mq.size() != DEPTH);
      ov = (mq.size() != 0);
      if (ov && ordy) void'(mq.pop_front());
      if (iv && ir) mq.push_back({(v > LIM), v});
      movf = (iv && !ir) ? 1'b1 : (clr ? 1'b0 : movf);
      cyc(iv, v, ordy, clr);
      chk($sformatf("r%0d_level", n), 32'(level), 32'(mq.size()));
      chk($sformatf("r%0d_ovf", n), 32'(ovf), 32'(movf));
      chk($sformatf("r%0d_out_valid", n), 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk($sformatf("r%0d_out_count", n), 32'(out_count), 32'(mq[0][15:0]));
        chk($sformatf("r%0d_out_oor", n), 32'(out_oor), 32'(RC && mq[0][16]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
